// File: rtl/stepper_phase_sequencer.sv
// Unipolar stepper phase sequencer: turns direction/enable/mode/rate controls
// into a four-coil drive pattern with counted or continuous runs.
module stepper_phase_sequencer #(
    parameter int unsigned PERIOD_W = 24,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                direction,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                start,
    input  logic [COUNT_W-1:0]  step_count,
    input  logic                stop,
    output logic [3:0]          coils,
    output logic                step_tick,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  position
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          state, state_nxt;
    logic [2:0]          idx, idx_nxt;
    logic [PERIOD_W-1:0] cnt, cnt_nxt;
    logic [COUNT_W-1:0]  rem, rem_nxt;
    logic [COUNT_W-1:0]  pos_nxt;
    logic [1:0]          mode_q, mode_nxt;
    logic                tick_nxt, done_nxt;
    logic [PERIOD_W-1:0] limit_m1;
    logic [2:0]          stride;

    // Half-step order; odd indices energize two adjacent coils.
    function automatic logic [3:0] phase_pattern(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    // A period of zero behaves as one clock per step.
    assign limit_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign stride   = (mode_q == 2'b00 || mode_q == 2'b01) ? 3'd2 : 3'd1;

    assign coils = (enable && !reset) ? phase_pattern(idx) : 4'b0000;
    assign busy  = (state == S_RUN);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        rem_nxt   = rem;
        pos_nxt   = position;
        mode_nxt  = mode_q;
        tick_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nxt = S_RUN;
                    mode_nxt  = mode;
                    rem_nxt   = step_count;
                    cnt_nxt   = '0;
                    // Snap onto the even (wave) or odd (full) index lattice.
                    case (mode)
                        2'b00:   idx_nxt = {idx[2:1], 1'b0};
                        2'b01:   idx_nxt = {idx[2:1], 1'b1};
                        default: idx_nxt = idx;
                    endcase
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (enable) begin
                    if (cnt >= limit_m1) begin
                        idx_nxt  = direction ? idx + stride : idx - stride;
                        pos_nxt  = direction ? position + COUNT_W'(1)
                                             : position - COUNT_W'(1);
                        cnt_nxt  = '0;
                        tick_nxt = 1'b1;
                        if (rem != '0) begin
                            rem_nxt = rem - COUNT_W'(1);
                            if (rem == COUNT_W'(1)) begin
                                state_nxt = S_IDLE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + PERIOD_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            rem       <= '0;
            position  <= '0;
            mode_q    <= 2'b00;
            step_tick <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            rem       <= rem_nxt;
            position  <= pos_nxt;
            mode_q    <= mode_nxt;
            step_tick <= tick_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Self-checking bench for stepper_phase_sequencer: vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_stepper_phase_sequencer;

    logic        clk;
    logic        rst, en, dir, st, sp;
    logic [1:0]  md;
    logic [23:0] per;
    logic [15:0] cnt_in;

    logic [3:0]  coils, coils_s;
    logic        step_tick, busy, done;
    logic        tick_s, busy_s, done_s;
    logic [15:0] position;
    logic [3:0]  pos_s;

    int tests = 0;
    int fails = 0;

    stepper_phase_sequencer dut (
        .clk(clk), .reset(rst), .direction(dir), .enable(en), .mode(md),
        .period(per), .start(st), .step_count(cnt_in), .stop(sp),
        .coils(coils), .step_tick(step_tick), .busy(busy), .done(done),
        .position(position)
    );

    stepper_phase_sequencer #(.PERIOD_W(24), .COUNT_W(4)) dut_s (
        .clk(clk), .reset(rst), .direction(dir), .enable(en), .mode(md),
        .period(per), .start(st), .step_count(cnt_in[3:0]), .stop(sp),
        .coils(coils_s), .step_tick(tick_s), .busy(busy_s), .done(done_s),
        .position(pos_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    int m_run, m_idx, m_cnt, m_rem, m_pos, m_mode, m_tick, m_done;

    function automatic int pat(input int i);
        case (i)
            0: return 1;  1: return 3;  2: return 2;  3: return 6;
            4: return 4;  5: return 12; 6: return 8;  default: return 9;
        endcase
    endfunction

    task automatic model_step();
        int lim, strd;
        m_tick = 0;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_idx = 0; m_cnt = 0; m_rem = 0; m_pos = 0; m_mode = 0;
        end else if (m_run == 0) begin
            if (st && !sp) begin
                m_run  = 1;
                m_mode = int'(md);
                m_rem  = int'(cnt_in);
                m_cnt  = 0;
                if (md == 2'd0)      m_idx = (m_idx / 2) * 2;
                else if (md == 2'd1) m_idx = (m_idx / 2) * 2 + 1;
            end
        end else if (sp) begin
            m_run = 0;
        end else if (en) begin
            lim = (per == 0) ? 1 : int'(per);
            if (m_cnt >= lim - 1) begin
                strd   = (m_mode >= 2) ? 1 : 2;
                m_idx  = dir ? (m_idx + strd) % 8 : (m_idx + 8 - strd) % 8;
                m_pos  = dir ? m_pos + 1 : m_pos - 1;
                m_cnt  = 0;
                m_tick = 1;
                if (m_rem != 0) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_run  = 0;
                        m_done = 1;
                    end
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_coils", int'(coils), (en && !rst) ? pat(m_idx) : 0);
        chk("model_tick", int'(step_tick), m_tick);
        chk("model_busy", int'(busy), m_run);
        chk("model_done", int'(done), m_done);
        chk("model_pos", int'(position), m_pos & 32'hFFFF);
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; st = 1'b0; sp = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_count(input int n, inout int ticks, inout int dones);
        for (int i = 0; i < n; i++) begin
            cycle();
            ticks += int'(step_tick);
            dones += int'(done);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, en, dir;
        logic [1:0]  md;
        logic [23:0] per;
        logic        st;
        logic [15:0] cnt;
        logic        sp;
        logic [3:0]  coils;
        logic        tick, busy, done;
        logic [15:0] pos;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int ticks, dones, first, done_at, last;
        int seq[$];
        int exp_half[8];
        int exp_wave[5];
        int got;

        rst = 1'b1; en = 1'b0; dir = 1'b0; md = 2'b00; per = 24'd1;
        st = 1'b0; cnt_in = 16'd0; sp = 1'b0;

        //          rst  en   dir  md     per    st   cnt    sp   coils tick busy done pos
        vecs[0]  = '{1'b1,1'b1,1'b0,2'd0,24'd1,1'b0,16'd0,1'b0,4'h0,1'b0,1'b0,1'b0,16'h0000};
        vecs[1]  = '{1'b0,1'b1,1'b0,2'd1,24'd1,1'b1,16'd3,1'b0,4'h3,1'b0,1'b1,1'b0,16'h0000};
        vecs[2]  = '{1'b0,1'b1,1'b0,2'd1,24'd1,1'b0,16'd3,1'b0,4'h9,1'b1,1'b1,1'b0,16'hFFFF};
        vecs[3]  = '{1'b0,1'b1,1'b0,2'd1,24'd1,1'b0,16'd3,1'b0,4'hC,1'b1,1'b1,1'b0,16'hFFFE};
        vecs[4]  = '{1'b0,1'b1,1'b0,2'd1,24'd1,1'b0,16'd3,1'b0,4'h6,1'b1,1'b0,1'b1,16'hFFFD};
        vecs[5]  = '{1'b0,1'b1,1'b0,2'd1,24'd1,1'b0,16'd3,1'b0,4'h6,1'b0,1'b0,1'b0,16'hFFFD};
        vecs[6]  = '{1'b0,1'b0,1'b0,2'd1,24'd1,1'b0,16'd3,1'b0,4'h0,1'b0,1'b0,1'b0,16'hFFFD};
        vecs[7]  = '{1'b1,1'b1,1'b0,2'd1,24'd1,1'b0,16'd3,1'b0,4'h0,1'b0,1'b0,1'b0,16'h0000};
        vecs[8]  = '{1'b0,1'b1,1'b1,2'd2,24'd1,1'b1,16'd5,1'b1,4'h1,1'b0,1'b0,1'b0,16'h0000};
        vecs[9]  = '{1'b0,1'b1,1'b1,2'd2,24'd1,1'b0,16'd5,1'b0,4'h1,1'b0,1'b0,1'b0,16'h0000};
        vecs[10] = '{1'b0,1'b1,1'b1,2'd2,24'd0,1'b1,16'd2,1'b0,4'h1,1'b0,1'b1,1'b0,16'h0000};
        vecs[11] = '{1'b0,1'b1,1'b1,2'd2,24'd0,1'b0,16'd2,1'b0,4'h3,1'b1,1'b1,1'b0,16'h0001};
        vecs[12] = '{1'b0,1'b1,1'b1,2'd2,24'd0,1'b0,16'd2,1'b0,4'h2,1'b1,1'b0,1'b1,16'h0002};
        vecs[13] = '{1'b0,1'b1,1'b1,2'd2,24'd0,1'b0,16'd2,1'b0,4'h2,1'b0,1'b0,1'b0,16'h0002};

        for (int v = 0; v < 14; v++) begin
            rst = vecs[v].rst; en = vecs[v].en; dir = vecs[v].dir; md = vecs[v].md;
            per = vecs[v].per; st = vecs[v].st; cnt_in = vecs[v].cnt; sp = vecs[v].sp;
            cycle();
            chk($sformatf("vec%0d_coils", v), int'(coils), int'(vecs[v].coils));
            chk($sformatf("vec%0d_tick", v), int'(step_tick), int'(vecs[v].tick));
            chk($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].busy));
            chk($sformatf("vec%0d_done", v), int'(done), int'(vecs[v].done));
            chk($sformatf("vec%0d_pos", v), int'(position), int'(vecs[v].pos));
        end

        // Half-step counted run, period 4.
        exp_half = '{3, 2, 6, 4, 12, 8, 9, 1};
        do_reset();
        en = 1'b1; md = 2'd2; dir = 1'b1; per = 24'd4; cnt_in = 16'd8; st = 1'b1;
        cycle();
        st = 1'b0;
        ticks = 0; first = -1; done_at = -1; last = -1; seq.delete();
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (step_tick) begin
                ticks++;
                if (first < 0) first = k;
                last = k;
                seq.push_back(int'(coils));
            end
            if (done) done_at = k;
        end
        chk("half_ticks", ticks, 8);
        chk("half_first_tick", first, 4);
        chk("half_last_tick", last, 32);
        chk("half_done_at", done_at, 32);
        chk("half_pos", int'(position), 8);
        chk("half_busy_end", int'(busy), 0);
        for (int i = 0; i < 8; i++) begin
            got = (i < seq.size()) ? seq[i] : -1;
            chk($sformatf("half_coils%0d", i), got, exp_half[i]);
        end

        // Wave continuous, stop raised while a step is due.
        exp_wave = '{2, 4, 8, 1, 2};
        do_reset();
        en = 1'b1; md = 2'd0; dir = 1'b1; per = 24'd2; cnt_in = 16'd0; st = 1'b1;
        cycle();
        st = 1'b0;
        ticks = 0; seq.delete();
        for (int k = 0; k < 30 && ticks < 5; k++) begin
            cycle();
            if (step_tick) begin
                ticks++;
                seq.push_back(int'(coils));
            end
        end
        chk("wave_ticks_seen", ticks, 5);
        for (int i = 0; i < 5; i++) begin
            got = (i < seq.size()) ? seq[i] : -1;
            chk($sformatf("wave_coils%0d", i), got, exp_wave[i]);
        end
        cycle();
        sp = 1'b1;
        cycle();
        sp = 1'b0;
        chk("wave_stop_tick", int'(step_tick), 0);
        chk("wave_stop_busy", int'(busy), 0);
        ticks = 0; dones = 0;
        run_count(6, ticks, dones);
        chk("wave_after_ticks", ticks, 0);
        chk("wave_after_done", dones, 0);

        // Enable pause mid-run.
        do_reset();
        en = 1'b1; md = 2'd2; dir = 1'b1; per = 24'd3; cnt_in = 16'd6; st = 1'b1;
        cycle();
        st = 1'b0;
        ticks = 0;
        for (int k = 0; k < 20 && ticks < 2; k++) begin
            cycle();
            ticks += int'(step_tick);
        end
        cycle();
        en = 1'b0;
        first = 0; got = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            first += int'(step_tick);
            got   += int'(coils != 4'b0000);
        end
        chk("pause_ticks", first, 0);
        chk("pause_coils_on", got, 0);
        en = 1'b1;
        done_at = 0;
        for (int k = 0; k < 40 && done_at == 0; k++) begin
            cycle();
            ticks += int'(step_tick);
            done_at += int'(done);
        end
        chk("pause_total_ticks", ticks, 6);
        chk("pause_done", done_at, 1);
        chk("pause_pos", int'(position), 6);

        // Start while busy is ignored.
        do_reset();
        en = 1'b1; md = 2'd2; dir = 1'b1; per = 24'd4; cnt_in = 16'd4; st = 1'b1;
        cycle();
        st = 1'b0;
        ticks = 0; dones = 0;
        run_count(5, ticks, dones);
        cnt_in = 16'd100; st = 1'b1;
        cycle();
        ticks += int'(step_tick);
        st = 1'b0;
        run_count(40, ticks, dones);
        chk("busy_start_ticks", ticks, 4);
        chk("busy_start_dones", dones, 1);

        // Lowering period mid-count forces a step on the next edge.
        do_reset();
        en = 1'b1; md = 2'd2; dir = 1'b1; per = 24'd100; cnt_in = 16'd0; st = 1'b1;
        cycle();
        st = 1'b0;
        ticks = 0; dones = 0;
        run_count(50, ticks, dones);
        chk("lower_no_early_tick", ticks, 0);
        per = 24'd2;
        cycle();
        chk("lower_tick", int'(step_tick), 1);

        // Reset mid-run.
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_coils", int'(coils), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pos", int'(position), 0);
        rst = 1'b0;

        // Position wrap on the 4-bit instance: 17 forward steps.
        do_reset();
        en = 1'b1; md = 2'd2; dir = 1'b1; per = 24'd1; cnt_in = 16'd0; st = 1'b1;
        cycle();
        st = 1'b0;
        ticks = 0;
        for (int k = 0; k < 40 && ticks < 17; k++) begin
            cycle();
            ticks += int'(step_tick);
        end
        sp = 1'b1;
        cycle();
        sp = 1'b0;
        chk("wrap_ticks", ticks, 17);
        chk("wrap_pos_small", int'(pos_s), 1);
        chk("wrap_pos_wide", int'(position), 17);
        chk("wrap_coils_small", int'(coils_s), 3);
        chk("wrap_busy_small", int'(busy_s), 0);
        chk("wrap_flags_small", int'(tick_s) + int'(done_s), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            dir = ($urandom_range(0, 7) != 0) ? dir : ~dir;
            md  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) per = 24'($urandom_range(0, 5));
            st  = ($urandom_range(0, 9) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            cnt_in = 16'($urandom_range(0, 6));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stepper_phase_sequencer.md
Name: stepper_phase_sequencer

Overview:
- Downstream consumer of the 1-bit direction PIO in the unipolar stepper system.
- Turns direction, enable, mode and step-rate controls into the four-coil drive pattern for a unipolar stepper.
- Provides a step-count run with busy/done handshake, a per-step tick and a signed position counter.
- Sits between the PIO/Nios register outputs and the coil driver pins.

Parameters:
- PERIOD_W, 24, width of step period (clock cycles per step).
- COUNT_W, 16, width of step_count request and position counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- direction  in  1  1 = forward (phase index +), 0 = reverse; sampled at every step edge
- enable  in  1  coil drive enable; 0 de-energizes coils and freezes stepping
- mode  in  2  00 wave, 01 full, 10 half, 11 treated as half; latched on start
- period  in  PERIOD_W  clocks per step; 0 treated as 1; read live
- start  in  1  one-cycle request to begin a run (ignored while busy)
- step_count  in  COUNT_W  steps to execute, latched on start; 0 = continuous until stop
- stop  in  1  abort run
- coils  out  4  {D,C,B,A} coil drive
- step_tick  out  1  one-cycle pulse per executed step
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when a counted run completes
- position  out  COUNT_W  two's-complement step position, wraps modulo 2^COUNT_W

Behaviour:
- Reset (sync, clk edge with reset=1): state IDLE, phase idx=0, prescaler cnt=0, remaining=0, position=0, step_tick=0, busy=0, done=0, mode latch=00, coils=0000.
- Phase table idx 0..7 -> coils: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- coils = table[idx] when enable=1, else 0000; coils are 0000 whenever reset is asserted.
- Stride: half = ±1; wave/full = ±2; idx arithmetic is modulo 8.
- On start acceptance, idx is aligned: wave -> {idx[2:1],0}; full -> {idx[2:1],1}; half -> unchanged.
- IDLE state:
  - busy=0; coils hold the last pattern, gated by enable.
  - start=1 and stop=0 -> RUN. Latch mode, remaining<=step_count, cnt<=0, apply alignment, busy=1 from next cycle.
- RUN state:
  - enable=0: cnt, idx and remaining frozen; no ticks.
  - enable=1 and cnt >= max(period,1)-1: a step edge occurs.
    - idx += stride if direction=1, else idx -= stride.
    - position ±1, following the same direction.
    - cnt<=0; step_tick=1 for the following cycle.
    - If remaining!=0, decrement it. If that decrement reaches 0: go to IDLE and pulse done together with the final step_tick.
  - Otherwise cnt++.
  - With period=P, the first step_tick is visible P cycles after the cycle in which start was sampled; later ticks follow every P cycles.
  - Continuous mode (step_count=0) never asserts done.
- stop=1 in RUN: -> IDLE at that edge; no step even if one is due; no done pulse.
- start and stop in the same cycle: stop wins and no run begins. start while busy: ignored.
- period lowered mid-run: the >= compare forces a step on the next edge. period raised mid-run: current cnt continues counting to the new limit.
- direction change mid-run takes effect at the next step edge. mode change mid-run is ignored until the next start.
- Reset mid-run: immediate return to reset values; coils=0000.

Test Plan:
- Reset, then enable=1, mode=10, dir=1, period=4, step_count=8, start pulse -> step_tick every 4 cycles, first at 4 cycles after start. Coils step 0011,0010,0110,0100,1100,1000,1001,0001. done coincides with the 8th tick; position=8; busy falls.
- Reverse full-step: idx=0, mode=01, dir=0, period=1, step_count=3 -> align idx=1, then coils 1001,1100,0110. position = -3 (0xFFFD); one tick per cycle.
- Wave, continuous: mode=00, step_count=0, period=2 -> coils cycle 0001,0010,0100,1000, repeating. Raise stop after 5 ticks -> busy=0 next cycle, no done pulse, no sixth tick.
- Enable pause: drop enable for 10 cycles mid-run with period=3 -> coils=0000, no ticks, cnt held. Restore enable -> stepping resumes with the remaining count intact; total ticks equal step_count.
- Corner cases:
  - period=0 behaves as period=1.
  - start+stop in the same cycle -> busy stays 0.
  - start while busy has no effect.
  - Lowering period from 100 to 2 at cnt=50 -> tick on the next cycle.
- Reset asserted mid-run -> coils=0000, busy=0, position=0 on the following cycle. position wrap check: COUNT_W=4, 17 forward steps -> position=1.
